// File: rtl/b_type_branch_unit_pkg.sv
// Shared definitions for the B-type branch resolution unit.
package b_type_branch_unit_pkg;

    localparam int XLEN = 32;

    // Sequential fetch step for a 32-bit instruction.
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    // Branch condition encodings carried in funct3 (3'b010/011 are unused).
    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } b_func;

    // funct3 field of an RV32I instruction word.
    function automatic logic [2:0] funct3_of(input logic [XLEN-1:0] instr);
        return instr[14:12];
    endfunction

endpackage

// File: rtl/b_type_branch_unit_cmp.sv
// Branch condition evaluation: compares rv1/rv2 as selected by funct3.
module b_type_branch_unit_cmp
    import b_type_branch_unit_pkg::*;
(
    input  logic signed [XLEN-1:0] rv1_i,
    input  logic signed [XLEN-1:0] rv2_i,
    input  logic        [2:0]      funct3_i,
    output logic                   taken_o
);

    // Enum view of funct3 so waveforms show the mnemonic.
    b_func func;
    logic  eq;
    logic  lt_s;
    logic  lt_u;

    assign func = b_func'(funct3_i);
    assign eq   = (rv1_i == rv2_i);
    assign lt_s = (rv1_i < rv2_i);
    assign lt_u = ($unsigned(rv1_i) < $unsigned(rv2_i));

    // Select the branch condition; undefined encodings never branch.
    always_comb begin
        taken_o = 1'b0;
        case (func)
            BEQ:     taken_o = eq;
            BNE:     taken_o = !eq;
            BLT:     taken_o = lt_s;
            BGE:     taken_o = !lt_s;
            BLTU:    taken_o = lt_u;
            BGEU:    taken_o = !lt_u;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/b_type_branch_unit.sv
// Combinational B-type branch resolution: computes the next fetch address.
// clk/reset are part of the shared instruction interface but play no role
// here; the output depends only on the datapath inputs.
module b_type_branch_unit
    import b_type_branch_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic        [XLEN-1:0] iaddr,
    input  logic        [XLEN-1:0] idata,
    input  logic signed [XLEN-1:0] imm,
    input  logic signed [XLEN-1:0] rv1,
    input  logic signed [XLEN-1:0] rv2,
    output logic        [XLEN-1:0] iaddr_val
);

    logic [2:0]      funct3;
    logic            taken;
    logic [XLEN-1:0] target_pc;
    logic [XLEN-1:0] seq_pc;
    logic            unused_ok;

    assign funct3 = funct3_of(idata);

    // Opcode/register fields and the clock/reset are deliberately ignored.
    assign unused_ok = ^{clk, reset, idata[31:15], idata[11:0]};

    b_type_branch_unit_cmp u_branch_cmp (
        .rv1_i    (rv1),
        .rv2_i    (rv2),
        .funct3_i (funct3),
        .taken_o  (taken)
    );

    // Both adders wrap modulo 2^32; imm is a byte offset used as given.
    assign target_pc = iaddr + imm;
    assign seq_pc    = iaddr + PC_STEP;

    // Next-PC select.
    always_comb begin
        iaddr_val = seq_pc;
        if (taken) begin
            iaddr_val = target_pc;
        end
    end

endmodule

// File: tb/tb_b_type_branch_unit.sv
// Scoreboard bench for the combinational branch resolution unit.
module tb_b_type_branch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic [31:0] imm;
    logic [31:0] rv1;
    logic [31:0] rv2;
    wire  [31:0] iaddr_val;

    int vecs        = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    event sample_ev;
    bit   clk_run = 1'b0;

    b_type_branch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .iaddr     (iaddr),
        .idata     (idata),
        .imm       (imm),
        .rv1       (rv1),
        .rv2       (rv2),
        .iaddr_val (iaddr_val)
    );

    // Clock stays idle for the directed phase, then runs for the random phase.
    initial begin
        clk = 1'b0;
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    // Reference: branch rules evaluated on wide integers, result reduced mod 2^32.
    function automatic logic [31:0] ref_next(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] pc,
                                             input logic [31:0] off);
        longint sa;
        longint sbv;
        longint ua;
        longint ub;
        longint nxt;
        bit     t;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        case (f3)
            3'd0:    t = (ua == ub);
            3'd1:    t = (ua != ub);
            3'd4:    t = (sa < sbv);
            3'd5:    t = (sa >= sbv);
            3'd6:    t = (ua < ub);
            3'd7:    t = (ua >= ub);
            default: t = 1'b0;
        endcase
        if (t) nxt = longint'(pc) + longint'($signed(off));
        else   nxt = longint'(pc) + 64'sd4;
        return nxt[31:0];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_0001;
            default: return $urandom();
        endcase
    endfunction

    // Drive one vector, let it settle 1 time unit, queue the expectation.
    task automatic apply(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] off,
                         input logic [31:0] exp, input string name);
        logic [31:0] w;
        exp_t        e;
        w      = $urandom();
        w[14:12] = f3;
        idata  = w;
        rv1    = a;
        rv2    = b;
        iaddr  = pc;
        imm    = off;
        #1;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    // Monitor: compares the DUT output each time a vector is presented.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_underflow: no expectation queued at t=%0t", $time);
            end else begin
                e = sb_q.pop_front();
                vecs++;
                if (iaddr_val !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s: iaddr_val=%08h expected %08h (funct3=%0d rv1=%08h rv2=%08h iaddr=%08h imm=%08h)",
                             e.name, iaddr_val, e.exp, idata[14:12], rv1, rv2, iaddr, imm);
                end
            end
        end
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] off;
        int          waited;

        reset = 1'bx;
        iaddr = '0;
        idata = '0;
        imm   = '0;
        rv1   = '0;
        rv2   = '0;
        #3;

        // Directed vectors, clock idle and reset undriven.
        apply(3'b000, 32'd10, 32'd10,            32'h0, 32'hFF, 32'h0000_00FF, "beq_taken");
        apply(3'b000, 32'd5,  32'd10,            32'h0, 32'hFF, 32'h0000_0004, "beq_not_taken");
        apply(3'b001, 32'd10, 32'd10,            32'h0, 32'hFF, 32'h0000_0004, "bne_not_taken");
        apply(3'b001, 32'd5,  32'd10,            32'h0, 32'hFF, 32'h0000_00FF, "bne_taken");
        apply(3'b100, 32'd10, 32'd15,            32'h0, 32'hFF, 32'h0000_00FF, "blt_taken");
        apply(3'b100, 32'd10, 32'hFFFF_FFF1,     32'h0, 32'hFF, 32'h0000_0004, "blt_neg_not_taken");
        apply(3'b101, 32'd10, 32'hFFFF_FFF1,     32'h0, 32'hFF, 32'h0000_00FF, "bge_neg_taken");
        apply(3'b101, 32'd10, 32'd15,            32'h0, 32'hFF, 32'h0000_0004, "bge_not_taken");
        apply(3'b111, 32'd10, 32'd5,             32'h0, 32'hFF, 32'h0000_00FF, "bgeu_taken");
        apply(3'b110, 32'd10, 32'd5,             32'h0, 32'hFF, 32'h0000_0004, "bltu_not_taken");
        apply(3'b110, 32'd10, 32'hFFFF_FFF1,     32'h0, 32'hFF, 32'h0000_00FF, "bltu_big_taken");
        apply(3'b111, 32'd10, 32'hFFFF_FFF1,     32'h0, 32'hFF, 32'h0000_0004, "bgeu_big_not_taken");
        apply(3'b010, 32'd7,  32'd7,             32'h0, 32'hFF, 32'h0000_0004, "illegal_010");
        apply(3'b011, 32'd7,  32'd7,             32'h0, 32'hFF, 32'h0000_0004, "illegal_011");
        apply(3'b001, 32'd3,  32'd3,     32'hFFFF_FFFC, 32'hFF, 32'h0000_0000, "seq_wrap");
        apply(3'b000, 32'd1,  32'd1,     32'h0000_0100, 32'hFFFF_FFF8, 32'h0000_00F8, "neg_offset");
        apply(3'b000, 32'd9,  32'd9,     32'hFFFF_FFF0, 32'h0000_0020, 32'h0000_0010, "target_wrap");
        apply(3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h40, 32'h11, 32'h0000_0044, "bge_extreme");
        apply(3'b110, 32'h7FFF_FFFF, 32'h8000_0000, 32'h40, 32'h11, 32'h0000_0051, "bltu_extreme");

        // Random vectors with the clock running and reset toggling.
        clk_run = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            reset = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            a   = pick_operand();
            b   = ($urandom_range(0, 3) == 0) ? a : pick_operand();
            pc  = pick_operand();
            off = ($urandom_range(0, 1) == 1) ? pick_operand() : 32'($signed($urandom_range(0, 4095)) - 2048);
            apply(f3, a, b, pc, off, ref_next(f3, a, b, pc, off), "random");
        end

        waited = 0;
        while (sb_q.size() != 0 && waited < 100) begin
            #1;
            waited++;
        end
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
